// File: rtl/rs232_frame_rx.sv
// rs232_frame_rx
// ----------------------------------------------------------------------------
// Front end of the RS-232 command path. It synchronises the raw RX pin,
// deserialises 8N1 bytes, and parses fixed 8-byte command frames:
//   STX(0x02) CMD D0 D1 D2 D3 RSV(0x00) ETX(0x03)
// Each accepted frame produces a one-cycle cmd_valid strobe. Each malformed
// frame produces a one-cycle frame_err strobe and is dropped.
//
// Parameters
//   CLK_DIV      clk cycles per bit (>= 4)
//   TIMEOUT_CYC  max idle clk cycles between bytes inside a frame
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   rx           raw asynchronous serial input, idle high
//   cmd_valid    one-cycle strobe, frame accepted
//   cmd_write    CMD[7]; 1 = write, 0 = read (held until next cmd_valid)
//   cmd_addr     CMD[6:0], word address        (held until next cmd_valid)
//   cmd_wdata    {D0,D1,D2,D3}, D0 is the MSB  (held until next cmd_valid)
//   frame_err    one-cycle strobe, frame rejected
//   byte_valid   one-cycle strobe per correctly framed byte (debug)
//   byte_data    last correctly framed byte
// ----------------------------------------------------------------------------
module rs232_frame_rx #(
    parameter int CLK_DIV     = 434,
    parameter int TIMEOUT_CYC = 8680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        cmd_valid,
    output logic        cmd_write,
    output logic [6:0]  cmd_addr,
    output logic [31:0] cmd_wdata,
    output logic        frame_err,
    output logic        byte_valid,
    output logic [7:0]  byte_data
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] IDLE_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [2:0] {
        F_WAIT_STX = 3'd0,
        F_CMD      = 3'd1,
        F_D0       = 3'd2,
        F_D1       = 3'd3,
        F_D2       = 3'd4,
        F_D3       = 3'd5,
        F_RSV      = 3'd6,
        F_ETX      = 3'd7
    } frame_state_t;

    // Synchroniser
    logic sync1_q;
    logic rx_s_q;

    // Bit receiver
    bit_state_t    bit_state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          stop_wait_q;
    logic          byte_valid_q;
    logic [7:0]    byte_data_q;
    logic          byte_ferr_q;

    // Frame parser
    frame_state_t  frame_state_q;
    logic [TW-1:0] idle_q;
    logic [7:0]    cmd_byte_q;
    logic [31:0]   stage_q;
    logic          cmd_valid_q;
    logic          cmd_write_q;
    logic [6:0]    cmd_addr_q;
    logic [31:0]   cmd_wdata_q;
    logic          frame_err_q;

    // Combinational helpers
    logic bit_tick_d;
    logic frame_open_d;

    assign bit_tick_d   = (cnt_q == CNT_ZERO);
    assign frame_open_d = (frame_state_q != F_WAIT_STX);

    // Two-flop synchroniser on the raw pin; preset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Bit receiver: start-bit qualification, mid-bit sampling, stop-bit check
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_state_q  <= B_IDLE;
            cnt_q        <= CNT_ZERO;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            stop_wait_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_ferr_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            byte_ferr_q  <= 1'b0;
            case (bit_state_q)
                B_IDLE: begin
                    if (!rx_s_q) begin
                        // Half a bit from the edge lands in the middle of the start bit
                        cnt_q       <= CNT_HALF;
                        bit_state_q <= B_START;
                    end
                end
                B_START: begin
                    if (bit_tick_d) begin
                        if (rx_s_q) begin
                            // Line back high mid start bit: treat as a glitch
                            bit_state_q <= B_IDLE;
                        end else begin
                            cnt_q       <= CNT_FULL;
                            bit_idx_q   <= 3'd0;
                            bit_state_q <= B_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                B_DATA: begin
                    if (bit_tick_d) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= CNT_FULL;
                        if (bit_idx_q == 3'd7) begin
                            bit_state_q <= B_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                B_STOP: begin
                    if (stop_wait_q) begin
                        // After a framing error, only a high line may start a new search
                        if (rx_s_q) begin
                            stop_wait_q <= 1'b0;
                            bit_state_q <= B_IDLE;
                        end
                    end else if (bit_tick_d) begin
                        if (rx_s_q) begin
                            byte_data_q  <= shift_q;
                            byte_valid_q <= 1'b1;
                            bit_state_q  <= B_IDLE;
                        end else begin
                            byte_ferr_q <= 1'b1;
                            stop_wait_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    bit_state_q <= B_IDLE;
                end
            endcase
        end
    end

    // Frame parser: walks the 8-byte frame, checks RSV/ETX, abandons stalled frames
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_state_q <= F_WAIT_STX;
            idle_q        <= IDLE_ZERO;
            cmd_byte_q    <= 8'h00;
            stage_q       <= 32'h0000_0000;
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= 7'h00;
            cmd_wdata_q   <= 32'h0000_0000;
            frame_err_q   <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (frame_open_d && byte_ferr_q) begin
                frame_err_q   <= 1'b1;
                frame_state_q <= F_WAIT_STX;
                idle_q        <= IDLE_ZERO;
            end else if (byte_valid_q) begin
                idle_q <= IDLE_ZERO;
                case (frame_state_q)
                    F_WAIT_STX: begin
                        if (byte_data_q == 8'h02) begin
                            frame_state_q <= F_CMD;
                        end
                    end
                    F_CMD: begin
                        cmd_byte_q    <= byte_data_q;
                        frame_state_q <= F_D0;
                    end
                    F_D0: begin
                        stage_q       <= {stage_q[23:0], byte_data_q};
                        frame_state_q <= F_D1;
                    end
                    F_D1: begin
                        stage_q       <= {stage_q[23:0], byte_data_q};
                        frame_state_q <= F_D2;
                    end
                    F_D2: begin
                        stage_q       <= {stage_q[23:0], byte_data_q};
                        frame_state_q <= F_D3;
                    end
                    F_D3: begin
                        stage_q       <= {stage_q[23:0], byte_data_q};
                        frame_state_q <= F_RSV;
                    end
                    F_RSV: begin
                        if (byte_data_q == 8'h00) begin
                            frame_state_q <= F_ETX;
                        end else begin
                            frame_err_q   <= 1'b1;
                            frame_state_q <= F_WAIT_STX;
                        end
                    end
                    F_ETX: begin
                        if (byte_data_q == 8'h03) begin
                            cmd_valid_q <= 1'b1;
                            cmd_write_q <= cmd_byte_q[7];
                            cmd_addr_q  <= cmd_byte_q[6:0];
                            cmd_wdata_q <= stage_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        frame_state_q <= F_WAIT_STX;
                    end
                    default: begin
                        frame_state_q <= F_WAIT_STX;
                    end
                endcase
            end else if (frame_open_d) begin
                // Inter-byte gap inside a frame; give up once it gets too long
                if (idle_q == IDLE_LAST) begin
                    frame_err_q   <= 1'b1;
                    frame_state_q <= F_WAIT_STX;
                    idle_q        <= IDLE_ZERO;
                end else begin
                    idle_q <= idle_q + IDLE_ONE;
                end
            end else begin
                idle_q <= IDLE_ZERO;
            end
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_write  = cmd_write_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_wdata  = cmd_wdata_q;
    assign frame_err  = frame_err_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;

endmodule

// File: tb/tb_rs232_frame_rx.sv
// Testbench for rs232_frame_rx: table-driven frame vectors, hand-written
// corner sequences (timeout, framing error, glitch, reset mid-frame) and
// randomized byte streams checked against a byte-level frame model.
module tb_rs232_frame_rx;

    localparam int CLK_DIV     = 16;
    localparam int TIMEOUT_CYC = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        cmd_valid;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        frame_err;
    logic        byte_valid;
    logic [7:0]  byte_data;

    always #5 clk = ~clk;

    rs232_frame_rx #(
        .CLK_DIV     (CLK_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .cmd_valid  (cmd_valid),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .frame_err  (frame_err),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    int total = 0;
    int bad   = 0;

    // Monitor state
    int          cyc = 0;
    int          err_cnt = 0;
    int          bv_cnt = 0;
    int          both_cnt = 0;
    int          last_err_cyc = 0;
    int          last_bv_cyc = 0;
    logic [39:0] cmd_q[$];
    logic [7:0]  rxb_q[$];

    // Reference model state
    logic [7:0]  stream_q[$];
    logic [39:0] exp_cmd_q[$];
    int          exp_err;

    typedef struct {
        logic [127:0] bytes;   // byte i at bytes[127-8*i -: 8]
        int           n;
        int           ncmd;
        int           nerr;
        logic [39:0]  first;   // {write, addr, wdata}
        logic [39:0]  last;
    } vec_t;

    vec_t vecs[7];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmd_valid) cmd_q.push_back({cmd_write, cmd_addr, cmd_wdata});
        if (frame_err) begin
            err_cnt      = err_cnt + 1;
            last_err_cyc = cyc;
        end
        if (byte_valid) begin
            bv_cnt      = bv_cnt + 1;
            last_bv_cyc = cyc;
            rxb_q.push_back(byte_data);
        end
        if (cmd_valid && frame_err) both_cnt = both_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        err_cnt = 0;
        bv_cnt  = 0;
        cmd_q.delete();
        rxb_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic set_vec(input int idx, input logic [127:0] b, input int n, input int ncmd,
                           input int nerr, input logic [39:0] first, input logic [39:0] last);
        vecs[idx].bytes = b;
        vecs[idx].n     = n;
        vecs[idx].ncmd  = ncmd;
        vecs[idx].nerr  = nerr;
        vecs[idx].first = first;
        vecs[idx].last  = last;
    endtask

    // Byte-level frame model: a frame is dropped the moment a field is wrong,
    // and a frame still open when the stream ends will be ended by timeout.
    task automatic run_model();
        int         pos;
        logic [7:0] fr[8];
        logic [7:0] b;
        exp_cmd_q.delete();
        exp_err = 0;
        pos = 0;
        for (int i = 0; i < stream_q.size(); i++) begin
            b = stream_q[i];
            if (pos == 0) begin
                if (b == 8'h02) pos = 1;
            end else begin
                fr[pos] = b;
                if (pos == 6 && b != 8'h00) begin
                    exp_err = exp_err + 1;
                    pos = 0;
                end else if (pos == 7) begin
                    if (b == 8'h03)
                        exp_cmd_q.push_back({fr[1][7], fr[1][6:0], fr[2], fr[3], fr[4], fr[5]});
                    else
                        exp_err = exp_err + 1;
                    pos = 0;
                end else begin
                    pos = pos + 1;
                end
            end
        end
        if (pos != 0) exp_err = exp_err + 1;
    endtask

    task automatic push_frame(input logic [7:0] cmd, input logic [31:0] d,
                              input logic [7:0] rsv, input logic [7:0] etx);
        stream_q.push_back(8'h02);
        stream_q.push_back(cmd);
        stream_q.push_back(d[31:24]);
        stream_q.push_back(d[23:16]);
        stream_q.push_back(d[15:8]);
        stream_q.push_back(d[7:0]);
        stream_q.push_back(rsv);
        stream_q.push_back(etx);
    endtask

    initial begin
        int          d;
        int          kind;
        int          gap;
        int          nmis;
        int          r;
        logic [7:0]  cmd_b;
        logic [31:0] data_w;
        logic [7:0]  exp_bytes[6];

        set_vec(0, 128'h02FF040816320003_0000000000000000, 8, 1, 0,
                {1'b1, 7'h7F, 32'h04081632}, {1'b1, 7'h7F, 32'h04081632});
        set_vec(1, 128'h027F000000000003_02FE0A0B0C0D0003, 16, 2, 0,
                {1'b0, 7'h7F, 32'h00000000}, {1'b1, 7'h7E, 32'h0A0B0C0D});
        set_vec(2, 128'h55AA027E000000000003_000000000000, 10, 1, 0,
                {1'b0, 7'h7E, 32'h00000000}, {1'b0, 7'h7E, 32'h00000000});
        set_vec(3, 128'h02FF010203040007_0000000000000000, 8, 0, 1, 40'h0, 40'h0);
        set_vec(4, 128'h0281DEADBEEF0003_0000000000000000, 8, 1, 0,
                {1'b1, 7'h01, 32'hDEADBEEF}, {1'b1, 7'h01, 32'hDEADBEEF});
        set_vec(5, 128'h0202020202020003_0000000000000000, 8, 1, 0,
                {1'b0, 7'h02, 32'h02020202}, {1'b0, 7'h02, 32'h02020202});
        set_vec(6, 128'h0210000000000103_0000000000000000, 8, 0, 1, 40'h0, 40'h0);

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs",
              {cmd_valid, cmd_write, cmd_addr, cmd_wdata, frame_err, byte_valid, byte_data}, 64'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(vecs[v].bytes[127 - 8 * i -: 8], 1'b1);
            repeat (60) @(negedge clk);
            check($sformatf("vec%0d_ncmd", v), cmd_q.size(), vecs[v].ncmd);
            check($sformatf("vec%0d_nerr", v), err_cnt, vecs[v].nerr);
            check($sformatf("vec%0d_nbytes", v), bv_cnt, vecs[v].n);
            if (vecs[v].ncmd > 0 && cmd_q.size() > 0) begin
                check($sformatf("vec%0d_first", v), cmd_q[0], vecs[v].first);
                check($sformatf("vec%0d_last", v), cmd_q[cmd_q.size() - 1], vecs[v].last);
                check($sformatf("vec%0d_hold", v), {cmd_write, cmd_addr, cmd_wdata}, vecs[v].last);
            end
        end

        // Inter-byte timeout inside a frame
        clear_mon();
        send_byte(8'h02, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (500) @(negedge clk);
        check("timeout_nerr", err_cnt, 1);
        check("timeout_ncmd", cmd_q.size(), 0);
        d = last_err_cyc - last_bv_cyc;
        total = total + 1;
        if (err_cnt == 0 || d < TIMEOUT_CYC || d > TIMEOUT_CYC + 2) begin
            bad = bad + 1;
            $display("FAIL timeout_delay actual=%0d required=%0d..%0d", d, TIMEOUT_CYC, TIMEOUT_CYC + 2);
        end

        // Framing error on D1's stop bit
        clear_mon();
        send_byte(8'h02, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (CLK_DIV) @(negedge clk);
        send_byte(8'h44, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (60) @(negedge clk);
        check("ferr_nbytes", bv_cnt, 6);
        check("ferr_nerr", err_cnt, 1);
        check("ferr_ncmd", cmd_q.size(), 0);
        exp_bytes = '{8'h02, 8'hFF, 8'h01, 8'h44, 8'h66, 8'h00};
        nmis = 0;
        for (int i = 0; i < 6; i++)
            if (i >= rxb_q.size() || rxb_q[i] !== exp_bytes[i]) nmis = nmis + 1;
        check("ferr_byte_data_mismatches", nmis, 0);

        // Short low glitch on an idle line
        clear_mon();
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_nbytes", bv_cnt, 0);
        check("glitch_nerr", err_cnt, 0);

        // Reset in the middle of D2, then a clean frame
        clear_mon();
        send_byte(8'h02, 1'b1);
        send_byte(8'h91, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        r = 8'hCC;
        for (int i = 0; i < 3; i++) begin
            rx = r[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midreset_outputs%0d", i),
                  {cmd_valid, cmd_write, cmd_addr, cmd_wdata, frame_err, byte_valid, byte_data}, 64'h0);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midreset_aborted_ncmd", cmd_q.size(), 0);
        check("midreset_aborted_nerr", err_cnt, 0);
        clear_mon();
        send_byte(8'h02, 1'b1);
        send_byte(8'h85, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (60) @(negedge clk);
        check("postreset_ncmd", cmd_q.size(), 1);
        check("postreset_nerr", err_cnt, 0);
        if (cmd_q.size() > 0)
            check("postreset_cmd", cmd_q[0], {1'b1, 7'h05, 32'h01020304});

        // Randomized streams against the byte-level model
        for (int t = 0; t < 3; t++) begin
            stream_q.delete();
            for (int k = 0; k < 5; k++) begin
                kind   = $urandom_range(0, 5);
                cmd_b  = 8'($urandom);
                data_w = $urandom;
                if (kind == 0) begin
                    stream_q.push_back(8'($urandom_range(0, 255)));
                end else if (kind == 4) begin
                    push_frame(cmd_b, data_w, 8'($urandom_range(1, 255)), 8'h03);
                end else if (kind == 5) begin
                    r = $urandom_range(0, 254);
                    if (r >= 3) r = r + 1;
                    push_frame(cmd_b, data_w, 8'h00, 8'(r));
                end else begin
                    push_frame(cmd_b, data_w, 8'h00, 8'h03);
                end
            end
            run_model();
            clear_mon();
            for (int i = 0; i < stream_q.size(); i++) begin
                send_byte(stream_q[i], 1'b1);
                gap = $urandom_range(0, 100);
                if (gap > 60) gap = 0;
                repeat (gap) @(negedge clk);
            end
            repeat (TIMEOUT_CYC + 100) @(negedge clk);
            check($sformatf("rand%0d_ncmd", t), cmd_q.size(), exp_cmd_q.size());
            for (int i = 0; i < exp_cmd_q.size() && i < cmd_q.size(); i++)
                check($sformatf("rand%0d_cmd%0d", t, i), cmd_q[i], exp_cmd_q[i]);
            check($sformatf("rand%0d_nerr", t), err_cnt, exp_err);
            check($sformatf("rand%0d_nbytes", t), bv_cnt, stream_q.size());
            nmis = 0;
            for (int i = 0; i < stream_q.size(); i++)
                if (i >= rxb_q.size() || rxb_q[i] !== stream_q[i]) nmis = nmis + 1;
            check($sformatf("rand%0d_byte_data_mismatches", t), nmis, 0);
        end

        check("valid_and_err_same_cycle", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
